// File: rtl/ahb_mmio_splitter.sv
// AHB-Lite one-master to NUM_SLAVES-slave MMIO splitter with a two-cycle default-slave ERROR responder.
// Optional wait-state watchdog enabled by defining AHB_SPLIT_TIMEOUT_EN.
module ahb_mmio_splitter #(
   parameter int NUM_SLAVES     = 4,
   parameter int DATA_W         = 32,
   parameter int SEL_LSB        = 12,
   parameter int SEL_W          = 4,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                         HCLK,
   input  logic                         HRESET,
   input  logic [31:0]                  HADDR,
   input  logic [1:0]                   HTRANS,
   input  logic                         HWRITE,
   input  logic [2:0]                   HSIZE,
   input  logic [2:0]                   HBURST,
   input  logic [3:0]                   HPROT,
   input  logic                         HMASTLOCK,
   input  logic [DATA_W-1:0]            HWDATA,
   output logic                         HREADY,
   output logic                         HRESP,
   output logic [DATA_W-1:0]            HRDATA,
   output logic [NUM_SLAVES-1:0]        S_HSEL,
   output logic [31:0]                  S_HADDR,
   output logic [1:0]                   S_HTRANS,
   output logic                         S_HWRITE,
   output logic [2:0]                   S_HSIZE,
   output logic [2:0]                   S_HBURST,
   output logic [3:0]                   S_HPROT,
   output logic                         S_HMASTLOCK,
   output logic [DATA_W-1:0]            S_HWDATA,
   output logic                         S_HREADY,
   input  logic [NUM_SLAVES-1:0]        S_HREADYOUT,
   input  logic [NUM_SLAVES-1:0]        S_HRESP,
   input  logic [NUM_SLAVES*DATA_W-1:0] S_HRDATA,
   output logic                         ERR_IRQ,
   output logic [31:0]                  ERR_ADDR
);

   localparam int IDX_W = 3;

   typedef enum logic [1:0] {D_NONE = 2'd0, D_SLAVE = 2'd1, D_DEFAULT = 2'd2} dsel_e;
   typedef enum logic [1:0] {E_IDLE = 2'd0, E_ERR1 = 2'd1, E_ERR2 = 2'd2} err_e;

   if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("ahb_mmio_splitter: parameter out of range");
   end

   dsel_e             dsel_q, dsel_d;
   logic [IDX_W-1:0]  didx_q, didx_d;
   err_e              err_q, err_d;
   logic [31:0]       pend_addr_q, pend_addr_d;
   logic [31:0]       err_addr_q, err_addr_d;
   logic              err_irq_q, err_irq_d;

   logic [SEL_W-1:0]      region_s;
   logic                  mapped_s;
   logic [NUM_SLAVES-1:0] hsel_s;
   logic                  hready_s;
   logic                  hresp_s;
   logic [DATA_W-1:0]     hrdata_s;
   logic                  accept_s;
   logic                  timeout_s;

   // Address-phase region decode, purely combinational from the master inputs.
   always_comb begin
      region_s = HADDR[SEL_LSB +: SEL_W];
      mapped_s = (32'(region_s) < 32'(NUM_SLAVES));
      hsel_s   = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         hsel_s[i] = HTRANS[1] && (32'(region_s) == 32'(i));
      end
   end

   // Data-phase response mux; depends only on registered owner and error state, never on HADDR.
   always_comb begin
      hready_s = 1'b1;
      hresp_s  = 1'b0;
      hrdata_s = '0;
      case (dsel_q)
         D_NONE: begin
            hready_s = 1'b1;
         end
         D_SLAVE: begin
            hready_s = 1'b0;
            for (int i = 0; i < NUM_SLAVES; i++) begin
               hready_s = hready_s | (S_HREADYOUT[i] & (didx_q == IDX_W'(i)));
               hresp_s  = hresp_s  | (S_HRESP[i]     & (didx_q == IDX_W'(i)));
               hrdata_s = hrdata_s | (S_HRDATA[i*DATA_W +: DATA_W] & {DATA_W{didx_q == IDX_W'(i)}});
            end
         end
         D_DEFAULT: begin
            case (err_q)
               E_ERR1: begin
                  hready_s = 1'b0;
                  hresp_s  = 1'b1;
               end
               E_ERR2: begin
                  hready_s = 1'b1;
                  hresp_s  = 1'b1;
               end
               default: begin
                  hready_s = 1'b1;
                  hresp_s  = 1'b0;
               end
            endcase
         end
         default: begin
            hready_s = 1'b1;
         end
      endcase
   end

`ifdef AHB_SPLIT_TIMEOUT_EN
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        stall_s;

   // Wait-state watchdog: counts owner-slave stall cycles, fires one cycle before the limit wraps.
   always_comb begin
      stall_s   = (dsel_q == D_SLAVE) && !hready_s;
      timeout_s = stall_s && (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));
      if (hready_s || timeout_s) begin
         wait_cnt_d = 16'd0;
      end else if (stall_s) begin
         wait_cnt_d = wait_cnt_q + 16'd1;
      end else begin
         wait_cnt_d = wait_cnt_q;
      end
   end

   // Watchdog counter register.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         wait_cnt_q <= 16'd0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end
`else
   assign timeout_s = 1'b0;
`endif

   // Owner, pending-address and error-sequencer next state.
   always_comb begin
      accept_s    = hready_s && HTRANS[1];
      dsel_d      = dsel_q;
      didx_d      = didx_q;
      pend_addr_d = pend_addr_q;
      if (timeout_s) begin
         dsel_d = D_DEFAULT;
      end else if (hready_s) begin
         if (HTRANS[1]) begin
            pend_addr_d = HADDR;
            if (mapped_s) begin
               dsel_d = D_SLAVE;
               didx_d = IDX_W'(region_s);
            end else begin
               dsel_d = D_DEFAULT;
            end
         end else begin
            dsel_d = D_NONE;
         end
      end else begin
         dsel_d = dsel_q;
      end

      err_d = E_IDLE;
      case (err_q)
         E_ERR1: begin
            err_d = E_ERR2;
         end
         E_IDLE, E_ERR2: begin
            if (timeout_s || (accept_s && !mapped_s)) begin
               err_d = E_ERR1;
            end else begin
               err_d = E_IDLE;
            end
         end
         default: begin
            err_d = E_IDLE;
         end
      endcase

      err_irq_d  = (err_q == E_ERR1);
      err_addr_d = (err_q == E_ERR2) ? pend_addr_q : err_addr_q;
   end

   // State and registered fault-report outputs.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         dsel_q      <= D_NONE;
         didx_q      <= '0;
         err_q       <= E_IDLE;
         pend_addr_q <= 32'd0;
         err_addr_q  <= 32'd0;
         err_irq_q   <= 1'b0;
      end else begin
         dsel_q      <= dsel_d;
         didx_q      <= didx_d;
         err_q       <= err_d;
         pend_addr_q <= pend_addr_d;
         err_addr_q  <= err_addr_d;
         err_irq_q   <= err_irq_d;
      end
   end

   assign HREADY      = hready_s;
   assign HRESP       = hresp_s;
   assign HRDATA      = hrdata_s;
   assign S_HREADY    = hready_s;
   assign S_HSEL      = hsel_s;
   assign S_HADDR     = HADDR;
   assign S_HTRANS    = HTRANS;
   assign S_HWRITE    = HWRITE;
   assign S_HSIZE     = HSIZE;
   assign S_HBURST    = HBURST;
   assign S_HPROT     = HPROT;
   assign S_HMASTLOCK = HMASTLOCK;
   assign S_HWDATA    = HWDATA;
   assign ERR_IRQ     = err_irq_q;
   assign ERR_ADDR    = err_addr_q;

endmodule

// File: tb/tb_ahb_mmio_splitter.sv
// Self-checking bench for ahb_mmio_splitter: directed cases plus random transfers against a transfer-level model.
module tb_ahb_mmio_splitter;
   localparam int NS = 4;
   localparam int DW = 32;

   logic           HCLK = 1'b0;
   logic           HRESET;
   logic [31:0]    HADDR;
   logic [1:0]     HTRANS;
   logic           HWRITE;
   logic [2:0]     HSIZE;
   logic [2:0]     HBURST;
   logic [3:0]     HPROT;
   logic           HMASTLOCK;
   logic [DW-1:0]  HWDATA;
   logic           HREADY, HRESP;
   logic [DW-1:0]  HRDATA;
   logic [NS-1:0]  S_HSEL;
   logic [31:0]    S_HADDR;
   logic [1:0]     S_HTRANS;
   logic           S_HWRITE;
   logic [2:0]     S_HSIZE, S_HBURST;
   logic [3:0]     S_HPROT;
   logic           S_HMASTLOCK;
   logic [DW-1:0]  S_HWDATA;
   logic           S_HREADY;
   logic [NS-1:0]  S_HREADYOUT;
   logic [NS-1:0]  S_HRESP;
   logic [NS*DW-1:0] S_HRDATA;
   logic           ERR_IRQ;
   logic [31:0]    ERR_ADDR;

   int n_chk = 0;
   int n_fail = 0;
   logic [31:0] exp_err_addr;

   ahb_mmio_splitter #(.NUM_SLAVES(NS), .DATA_W(DW), .SEL_LSB(12), .SEL_W(4), .TIMEOUT_CYCLES(8)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .S_HSEL(S_HSEL), .S_HADDR(S_HADDR),
      .S_HTRANS(S_HTRANS), .S_HWRITE(S_HWRITE), .S_HSIZE(S_HSIZE), .S_HBURST(S_HBURST),
      .S_HPROT(S_HPROT), .S_HMASTLOCK(S_HMASTLOCK), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
      .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP), .S_HRDATA(S_HRDATA),
      .ERR_IRQ(ERR_IRQ), .ERR_ADDR(ERR_ADDR)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #2;
   endtask

   task automatic idle_slaves();
      S_HREADYOUT = '1;
      S_HRESP     = '0;
      S_HRDATA    = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic junk_slaves();
      S_HREADYOUT = 4'($urandom);
      S_HRESP     = 4'($urandom);
      S_HRDATA    = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic chk_resp(input string tag, input logic rdy, input logic rsp, input logic irq);
      chk({tag, ".hready"},   32'(HREADY),   32'(rdy));
      chk({tag, ".s_hready"}, 32'(S_HREADY), 32'(rdy));
      chk({tag, ".hresp"},    32'(HRESP),    32'(rsp));
      chk({tag, ".irq"},      32'(ERR_IRQ),  32'(irq));
   endtask

   // One complete transfer followed by an idle cycle; slave r inserts `waits` wait states.
   task automatic do_xfer(input logic [31:0] addr, input logic wr, input int waits,
                          input logic serr, input logic [31:0] rdata);
      int r;
      logic [3:0]  exp_sel;
      logic [31:0] wdata;
      r       = int'(addr[15:12]);
      exp_sel = (r < NS) ? 4'(1 << r) : 4'b0000;
      wdata   = $urandom;
      idle_slaves();
      HADDR = addr; HTRANS = 2'b10; HWRITE = wr; HSIZE = 3'b010; HBURST = 3'b000;
      HPROT = 4'b0011; HMASTLOCK = 1'b0;
      #1;
      chk("addr.hsel",  32'(S_HSEL), 32'(exp_sel));
      chk("addr.haddr", S_HADDR, addr);
      chk("addr.hready", 32'(HREADY), 32'd1);
      tick();
      HTRANS = 2'b00; HADDR = $urandom; HWDATA = wdata;
      if (r < NS) begin
         for (int k = 0; k < waits; k++) begin
            junk_slaves();
            S_HREADYOUT[r] = 1'b0; S_HRESP[r] = 1'b0;
            #1;
            chk_resp("wait", 1'b0, 1'b0, 1'b0);
            chk("wait.hwdata", S_HWDATA, wdata);
            chk("data.hsel_idle", 32'(S_HSEL), 32'd0);
            tick();
         end
         if (serr) begin
            junk_slaves();
            S_HREADYOUT[r] = 1'b0; S_HRESP[r] = 1'b1;
            #1;
            chk_resp("serr1", 1'b0, 1'b1, 1'b0);
            tick();
            junk_slaves();
            S_HREADYOUT[r] = 1'b1; S_HRESP[r] = 1'b1;
            #1;
            chk_resp("serr2", 1'b1, 1'b1, 1'b0);
         end else begin
            junk_slaves();
            S_HREADYOUT[r] = 1'b1; S_HRESP[r] = 1'b0;
            S_HRDATA[r*DW +: DW] = rdata;
            #1;
            chk_resp("done", 1'b1, 1'b0, 1'b0);
            chk("done.hrdata", HRDATA, rdata);
            chk("done.hwdata", S_HWDATA, wdata);
         end
         tick();
      end else begin
         junk_slaves();
         #1;
         chk_resp("err1", 1'b0, 1'b1, 1'b0);
         chk("err1.hrdata", HRDATA, 32'd0);
         tick();
         junk_slaves();
         #1;
         chk_resp("err2", 1'b1, 1'b1, 1'b1);
         chk("err2.hrdata", HRDATA, 32'd0);
         exp_err_addr = addr;
         tick();
      end
      idle_slaves();
      #1;
      chk_resp("post", 1'b1, 1'b0, 1'b0);
      chk("post.err_addr", ERR_ADDR, exp_err_addr);
      chk("post.hrdata", HRDATA, 32'd0);
   endtask

   initial begin
      HRESET = 1'b1; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010;
      HBURST = 3'b000; HPROT = 4'b0011; HMASTLOCK = 1'b0; HWDATA = 32'd0;
      exp_err_addr = 32'd0;
      idle_slaves();
      tick();
      tick();
      chk_resp("reset", 1'b1, 1'b0, 1'b0);
      chk("reset.hrdata", HRDATA, 32'd0);
      chk("reset.err_addr", ERR_ADDR, 32'd0);
      chk("reset.hsel", 32'(S_HSEL), 32'd0);
      HRESET = 1'b0;
      tick();

      do_xfer(32'h0000_2000, 1'b0, 0, 1'b0, 32'hA5A5_0002);
      do_xfer(32'h0000_1010, 1'b1, 3, 1'b0, 32'h1111_2222);
      do_xfer(32'h0000_9004, 1'b0, 0, 1'b0, 32'h0);
      do_xfer(32'h0000_3008, 1'b0, 1, 1'b1, 32'h0);

      // Back-to-back unmapped transfers then a clean read from slave 0.
      idle_slaves();
      HADDR = 32'h0000_A100; HTRANS = 2'b10; HWRITE = 1'b0;
      #1;
      chk("bb.hsel_u1", 32'(S_HSEL), 32'd0);
      tick();
      HADDR = 32'h0000_F008;
      #1;
      chk_resp("bb.u1e1", 1'b0, 1'b1, 1'b0);
      tick();
      #1;
      chk_resp("bb.u1e2", 1'b1, 1'b1, 1'b1);
      tick();
      HADDR = 32'h0000_0040;
      #1;
      chk_resp("bb.u2e1", 1'b0, 1'b1, 1'b0);
      chk("bb.err_addr1", ERR_ADDR, 32'h0000_A100);
      tick();
      #1;
      chk_resp("bb.u2e2", 1'b1, 1'b1, 1'b1);
      chk("bb.hsel_s0", 32'(S_HSEL), 32'd1);
      tick();
      HTRANS = 2'b00;
      idle_slaves();
      S_HRDATA[31:0] = 32'hC0DE_0000;
      #1;
      chk_resp("bb.s0", 1'b1, 1'b0, 1'b0);
      chk("bb.s0.hrdata", HRDATA, 32'hC0DE_0000);
      chk("bb.err_addr2", ERR_ADDR, 32'h0000_F008);
      exp_err_addr = 32'h0000_F008;
      tick();

      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         a = $urandom;
         a[15:12] = 4'($urandom_range(0, 15));
         do_xfer(a, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                 ($urandom_range(0, 4) == 0), $urandom);
      end

      // Reset asserted while slave 3 is inserting wait states.
      idle_slaves();
      HADDR = 32'h0000_3010; HTRANS = 2'b10;
      tick();
      HTRANS = 2'b00;
      S_HREADYOUT[3] = 1'b0;
      #1;
      chk("rst3.hready_wait", 32'(HREADY), 32'd0);
      tick();
      HRESET = 1'b1;
      tick();
      #1;
      chk_resp("rst3", 1'b1, 1'b0, 1'b0);
      chk("rst3.err_addr", ERR_ADDR, 32'd0);
      chk("rst3.hrdata", HRDATA, 32'd0);
      HRESET = 1'b0;
      exp_err_addr = 32'd0;
      tick();
      do_xfer(32'h0000_7ABC, 1'b0, 0, 1'b0, 32'h0);

`ifdef AHB_SPLIT_TIMEOUT_EN
      // Slave 0 never becomes ready: eight wait cycles, then the error pair.
      idle_slaves();
      HADDR = 32'h0000_0ABC; HTRANS = 2'b10;
      tick();
      HTRANS = 2'b00;
      S_HREADYOUT[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk_resp("to.wait", 1'b0, 1'b0, 1'b0);
         tick();
      end
      #1;
      chk_resp("to.err1", 1'b0, 1'b1, 1'b0);
      tick();
      S_HREADYOUT[0] = 1'b1;
      #1;
      chk_resp("to.err2", 1'b1, 1'b1, 1'b1);
      tick();
      #1;
      chk_resp("to.post", 1'b1, 1'b0, 1'b0);
      chk("to.err_addr", ERR_ADDR, 32'h0000_0ABC);
      tick();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ahb_mmio_splitter.md
# ahb_mmio_splitter

Parametrised AHB-Lite one-master-to-N-slave splitter for the processor's MMIO port. It decodes the address phase into one of `NUM_SLAVES` slave selects and tracks the data-phase owner in a register. It muxes the owner's response back to the master. Unmapped or stalled accesses are terminated with a two-cycle AHB ERROR response, which is reported through an interrupt pulse and a captured fault address.

## Interface
Parameters:
- `NUM_SLAVES`, 4: number of slave ports, 1..8.
- `DATA_W`, 32: HWDATA/HRDATA width.
- `SEL_LSB`, 12: lowest HADDR bit of the region index.
- `SEL_W`, 4: width of the region index; region = `HADDR[SEL_LSB +: SEL_W]`.
- `TIMEOUT_CYCLES`, 256: wait-state limit, 2..65535. Only used with the `AHB_SPLIT_TIMEOUT_EN` macro.

Ports:
- `HCLK` in 1: single clock.
- `HRESET` in 1: synchronous, active-high reset.
- `HADDR` in 32: master address.
- `HTRANS` in 2: master transfer type.
- `HWRITE` in 1: master write flag.
- `HSIZE` in 3: master transfer size.
- `HBURST` in 3: master burst type.
- `HPROT` in 4: master protection.
- `HMASTLOCK` in 1: master lock.
- `HWDATA` in DATA_W: master write data.
- `HREADY` out 1: muxed ready to the master.
- `HRESP` out 1: muxed response (0 = OKAY, 1 = ERROR).
- `HRDATA` out DATA_W: muxed read data.
- `S_HSEL` out NUM_SLAVES: one-hot address-phase select.
- `S_HADDR`, `S_HTRANS`, `S_HWRITE`, `S_HSIZE`, `S_HBURST`, `S_HPROT`, `S_HMASTLOCK`, `S_HWDATA` out: broadcast copies of the master signals.
- `S_HREADY` out 1: HREADYIN to all slaves; equals `HREADY`.
- `S_HREADYOUT` in NUM_SLAVES: per-slave ready.
- `S_HRESP` in NUM_SLAVES: per-slave response.
- `S_HRDATA` in NUM_SLAVES*DATA_W: slave i's data sits at `[i*DATA_W +: DATA_W]`.
- `ERR_IRQ` out 1: one-cycle pulse per error termination.
- `ERR_ADDR` out 32: HADDR of the last errored transfer.

## Operation
- Address decode is combinational. `S_HSEL[r]=1` iff region `r` < NUM_SLAVES and `HTRANS[1]=1`; otherwise all selects are 0.
- The owner register is `dsel`, encoding NONE, SLAVE(i) or DEFAULT. It is updated only on `HCLK` edges where `HREADY=1`:
  - NONSEQ/SEQ with region < NUM_SLAVES gives SLAVE(region).
  - NONSEQ/SEQ with region ≥ NUM_SLAVES gives DEFAULT; HADDR is latched into a pending-address register.
  - IDLE/BUSY gives NONE.
- Data-phase mux:
  - NONE: `HREADY=1`, `HRESP=0`, `HRDATA=0`.
  - SLAVE(i): `S_HREADYOUT[i]`, `S_HRESP[i]` and slice i of `S_HRDATA`.
  - DEFAULT: driven by the error FSM.
- Error FSM states: `E_IDLE`, `E_ERR1`, `E_ERR2`.
  - `E_IDLE` → `E_ERR1` when `dsel` becomes DEFAULT.
  - `E_ERR1` drives `HREADY=0`, `HRESP=1`, then goes unconditionally to `E_ERR2`.
  - `E_ERR2` drives `HREADY=1`, `HRESP=1`, pulses `ERR_IRQ`, loads `ERR_ADDR` from the pending address, then returns to `E_IDLE`.
  - `HRDATA=0` throughout the error sequence.
- An address phase presented during `E_ERR2` is accepted normally, because `HREADY=1`. Back-to-back unmapped transfers therefore produce continuous ERR1/ERR2 pairs.
- A slave's ERROR response passes through unchanged. It does not pulse `ERR_IRQ` and does not update `ERR_ADDR`.
- Reset values: `dsel`=NONE, FSM=`E_IDLE`, `HREADY=1`, `HRESP=0`, `HRDATA=0`, `ERR_IRQ=0`, `ERR_ADDR=0`.
- `S_HSEL` is 0 in reset only while `HTRANS` is IDLE; it is combinational from the inputs.
- Reset mid-transfer aborts any data phase and returns to the reset state on the next edge. Slave state is not the splitter's responsibility.

## Timing
- Decode adds zero latency. A zero-wait slave completes in one data-phase cycle.
- Response mux latency is combinational from the registered `dsel`. There is no path from `HADDR` to `HREADY`.
- Default-slave response is exactly two cycles: ERR1 then ERR2.
- `ERR_IRQ` is high for exactly one cycle, coincident with ERR2. `ERR_ADDR` is valid from the following cycle.
- Critical path: `S_HREADYOUT[i]` → `HREADY` → `S_HREADY` → slave. No additional register stage is permitted on this path.

## Configuration
- `AHB_SPLIT_TIMEOUT_EN` defined:
  - A 16-bit counter increments each cycle `dsel`=SLAVE(i) and `S_HREADYOUT[i]=0`, and clears when `HREADY=1`.
  - When the count reaches `TIMEOUT_CYCLES`, the splitter overrides the owner, forces `dsel`=DEFAULT and runs ERR1/ERR2.
  - `ERR_ADDR` receives the stalled transfer's address.
  - The hung slave's later `S_HREADYOUT` is ignored.
- `AHB_SPLIT_TIMEOUT_EN` undefined: no counter or override logic; wait states are unbounded.

## Test plan
- Read from region 2 with a zero-wait slave 2 returning 0xA5A5_0002 → `S_HSEL`=4'b0100 in the address phase; next cycle `HRDATA`=0xA5A5_0002, `HREADY=1`, `HRESP=0`.
- Write to region 1 with slave 1 inserting 3 wait states → `HREADY` low for 3 cycles; `S_HREADY` mirrors it; `HWDATA` is held and broadcast.
- Read at HADDR=0x0000_9004 (region 9, NUM_SLAVES=4) → `HREADY=0`,`HRESP=1`, then `HREADY=1`,`HRESP=1`; `ERR_IRQ` pulses once; `ERR_ADDR`=0x0000_9004.
- Two back-to-back unmapped NONSEQ, then a region-0 read → two ERR pairs, two `ERR_IRQ` pulses, then a clean OKAY from slave 0.
- Assert `HRESET` during slave 3 wait states → the next cycle shows `HREADY=1`, `HRESP=0`, `ERR_ADDR=0`, FSM `E_IDLE`.
- With `AHB_SPLIT_TIMEOUT_EN` and TIMEOUT_CYCLES=8: slave 0 holds `S_HREADYOUT`=0 indefinitely → ERROR pair after 8 wait cycles; `ERR_ADDR` = the stalled address.
